// File: rtl/grayscale_frame_ctrl_if.sv
// Handshake and data bundle between the grayscale frame sequencer,
// the pixel source FIFO, the grayscale engine and the VGA/SDRAM side.
interface grayscale_frame_ctrl_if;
  logic       frame_start;
  logic       mode;
  logic       fifo_empty;
  logic       fifo_rdreq;
  logic       gs_start;
  logic       gs_read_req;
  logic       gs_valid;
  logic [9:0] gs_color;
  logic [9:0] gs_bw;
  logic [9:0] pix;
  logic       pix_valid;
  logic [10:0] x;
  logic [9:0] y;
  logic       busy;
  logic       frame_done;
  logic [1:0] err;

  modport master (
    input  frame_start, mode, fifo_empty,
    input  gs_read_req, gs_valid, gs_color, gs_bw,
    output fifo_rdreq, gs_start, pix, pix_valid,
    output x, y, busy, frame_done, err
  );

  modport slave (
    output frame_start, mode, fifo_empty,
    output gs_read_req, gs_valid, gs_color, gs_bw,
    input  fifo_rdreq, gs_start, pix, pix_valid,
    input  x, y, busy, frame_done, err
  );
endinterface

// File: rtl/grayscale_frame_ctrl.sv
// Frame sequencer for the grayscale engine: arms it, feeds it from the
// source FIFO, picks colour or B/W output and tracks pixel position.
module grayscale_frame_ctrl #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int MAX_OUTST = 4,
  parameter int TIMEOUT   = 4096
) (
  input logic clk,
  input logic rst,
  grayscale_frame_ctrl_if.master bus
);
  localparam int TOTAL = H_ACTIVE * V_ACTIVE;
  localparam int IW = $clog2(TOTAL + 1);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [IW-1:0] TOTAL_C = IW'(TOTAL);
  localparam logic [OW-1:0] OMAX = OW'(MAX_OUTST);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);
  localparam logic [10:0]   XL = 11'(H_ACTIVE - 1);
  localparam logic [9:0]    YL = 10'(V_ACTIVE - 1);

  typedef enum logic [2:0] {
    IDLE, RUN, DRAIN, DONE, ABORT
  } state_t;

  state_t          state;
  logic            mode;
  logic [IW-1:0]   issued;
  logic [OW-1:0]   outst;
  logic [TW-1:0]   timer;
  logic [10:0]     cx;
  logic [9:0]      cy;
  logic            pop;
  logic            accept;
  logic            active;
  logic            last;

  assign active = (state == RUN) || (state == DRAIN);

  assign pop = (state == RUN)
             && bus.gs_read_req
             && !bus.fifo_empty
             && (outst < OMAX)
             && (issued < TOTAL_C);

  assign accept = active && bus.gs_valid && (outst != '0);
  assign last = (cx == XL) && (cy == YL);
  assign bus.fifo_rdreq = pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      mode           <= 1'b0;
      issued         <= '0;
      outst          <= '0;
      timer          <= '0;
      cx             <= '0;
      cy             <= '0;
      bus.gs_start   <= 1'b0;
      bus.pix        <= '0;
      bus.pix_valid  <= 1'b0;
      bus.x          <= '0;
      bus.y          <= '0;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.err        <= '0;
    end else begin
      bus.pix_valid  <= 1'b0;
      bus.frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.frame_start) begin
            state        <= RUN;
            mode         <= bus.mode;
            issued       <= '0;
            outst        <= '0;
            timer        <= '0;
            cx           <= '0;
            cy           <= '0;
            bus.x        <= '0;
            bus.y        <= '0;
            bus.err      <= '0;
            bus.gs_start <= 1'b1;
            bus.busy     <= 1'b1;
          end
        end
        RUN, DRAIN: begin
          if (state == RUN && bus.gs_read_req && bus.fifo_empty)
            bus.err[0] <= 1'b1;
          // a result with nothing in flight is dropped
          if (bus.gs_valid && outst == '0)
            bus.err[0] <= 1'b1;
          if (pop)
            issued <= issued + 1'b1;
          outst <= outst + OW'(pop) - OW'(accept);
          if (accept) begin
            bus.pix_valid <= 1'b1;
            bus.pix <= mode ? bus.gs_bw : bus.gs_color;
            bus.x <= cx;
            bus.y <= cy;
            if (cx == XL) begin
              cx <= '0;
              cy <= cy + 1'b1;
            end else begin
              cx <= cx + 1'b1;
            end
          end
          timer <= bus.gs_valid ? '0 : timer + 1'b1;
          if (state == RUN && accept && last) begin
            state        <= DRAIN;
            timer        <= '0;
            bus.gs_start <= 1'b0;
          end else if (state == DRAIN && outst == '0) begin
            state          <= DONE;
            bus.frame_done <= 1'b1;
          end else if (!bus.gs_valid && timer == TLIM) begin
            state        <= ABORT;
            bus.gs_start <= 1'b0;
            bus.err[1]   <= 1'b1;
          end
        end
        DONE, ABORT: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
